// File: rtl/acc_pkg.sv
// Shared definitions for the product accumulator: default widths, block length and FSM encoding.
// Optional feature macro used by acc_add: PRODUCT_ACCUMULATOR_SATURATE_EN.
package acc_pkg;

    localparam int unsigned PW_DEF = 4;
    localparam int unsigned AW_DEF = 8;
    localparam int unsigned N_DEF  = 4;
    localparam int unsigned CW_DEF = $clog2(N_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_add.sv
// Combinational AW-bit unsigned adder producing a sum and carry-out.
// With PRODUCT_ACCUMULATOR_SATURATE_EN defined the sum clamps to all-ones on carry.
module acc_add
    import acc_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0] i_acc,
    input  logic [AW-1:0] i_prod,
    output logic [AW-1:0] o_sum,
    output logic          o_carry
);

    logic [AW:0] w_full;

    assign w_full  = {1'b0, i_acc} + {1'b0, i_prod};
    assign o_carry = w_full[AW];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // A clamped accumulator re-carries on any non-zero add, so it stays pinned.
    assign o_sum = w_full[AW] ? {AW{1'b1}} : w_full[AW-1:0];
`else
    assign o_sum = w_full[AW-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums N consecutive PW-bit products into an AW-bit block result with a sticky overflow flag.
// Saturating arithmetic is selected in acc_add by PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned PW = PW_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned N  = N_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf,
    output logic          busy
);

    localparam int unsigned CW = $clog2(N + 1);

    state_t        r_state;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_out_valid;
    logic [AW-1:0] r_out_sum;
    logic          r_out_ovf;

    logic [AW-1:0] w_prod_ext;
    logic [AW-1:0] w_sum;
    logic          w_carry;
    logic          w_accept;
    logic          w_last;

    assign w_prod_ext = AW'(in_prod);
    assign w_accept   = in_valid && r_in_ready;
    assign w_last     = (r_cnt + CW'(1)) == CW'(N);

    acc_add #(
        .AW (AW)
    ) u_acc_add (
        .i_acc   (r_acc),
        .i_prod  (w_prod_ext),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Block FSM; in_ready and busy are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end else if (w_accept) begin
                        r_acc   <= w_prod_ext;
                        r_cnt   <= CW'(1);
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (clr) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + CW'(1);
                        r_ovf <= r_ovf | w_carry;
                        if (w_last) begin
                            r_out_sum   <= w_sum;
                            r_out_ovf   <= r_ovf | w_carry;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // clr is ignored here so a presented result is never retracted.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: directed scenarios plus random traffic against a sum-of-products model.
module tb_product_accumulator;

    localparam int unsigned PW = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 4;

    typedef struct {
        logic [AW-1:0] sum;
        logic          ovf;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_ovf;
    logic          busy;

    exp_t        sb[$];
    int unsigned m_prods[$];
    bit          m_hold;
    int          n_checks;
    int          n_fail;

    product_accumulator #(
        .PW (PW),
        .AW (AW),
        .N  (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: the block result is the plain integer sum of its N products.
    function automatic exp_t block_result(input int unsigned prods[$]);
        exp_t        e;
        int unsigned tot;
        tot = 0;
        foreach (prods[i]) tot += prods[i];
        e.ovf = (tot >= (32'd1 << AW));
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        e.sum = e.ovf ? {AW{1'b1}} : AW'(tot);
`else
        e.sum = AW'(tot);
`endif
        return e;
    endfunction

    // One clock: drive, check handshake-level outputs, then advance the model past the edge.
    task automatic cyc(input logic v, input logic [PW-1:0] p, input logic ordy, input logic c);
        in_valid  = v;
        in_prod   = p;
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!m_hold));
        chk("busy", 32'(busy), 32'((m_prods.size() > 0) && !m_hold));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (c) begin
            m_prods.delete();
        end else if (v) begin
            m_prods.push_back(32'(p));
            if (m_prods.size() == N) begin
                sb.push_back(block_result(m_prods));
                m_prods.delete();
                m_hold = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic block4(input int a, input int b, input int c, input int d, input logic ordy);
        cyc(1'b1, PW'(a), ordy, 1'b0);
        cyc(1'b1, PW'(b), ordy, 1'b0);
        cyc(1'b1, PW'(c), ordy, 1'b0);
        cyc(1'b1, PW'(d), ordy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
    endtask

    // Asserts rst between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset(input string tag);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        m_prods.delete();
        m_hold = 1'b0;
        sb.delete();
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result must match the oldest expected block and stay stable until taken.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result at %0t: got out_sum=%0d with no block pending, expected none", $time, out_sum);
            end else begin
                chk("out_sum", 32'(out_sum), 32'(sb[0].sum));
                chk("out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
                if (out_ready) sb.delete(0);
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_hold    = 1'b0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic block with the consumer always ready.
        block4(9, 6, 4, 1, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        // Overflow beyond 2^AW.
        block4(9, 9, 9, 9, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: offered products must not be taken while the result waits.
        block4(1, 2, 3, 4, 1'b0);
        repeat (3) cyc(1'b1, PW'(7), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        block4(5, 0, 0, 1, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        // Bubbles, then clr beating a simultaneous accept.
        cyc(1'b1, PW'(3), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, PW'(2), 1'b1, 1'b0);
        cyc(1'b1, PW'(5), 1'b1, 1'b1);
        block4(1, 1, 1, 1, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        // clr while a result is held must not retract it.
        block4(9, 6, 4, 1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, PW'(3), 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-block, then a clean block.
        cyc(1'b1, PW'(2), 1'b1, 1'b0);
        cyc(1'b1, PW'(2), 1'b1, 1'b0);
        mid_reset("rst_mid");
        block4(2, 2, 2, 2, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while a result is held discards it.
        block4(15, 15, 15, 15, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        mid_reset("rst_hold");
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with bubbles, backpressure and occasional aborts.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0),
                PW'($urandom_range(0, (1 << PW) - 1)),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 24) == 0));
        end

        repeat (N + 3) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("results_outstanding", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
